// File: rtl/mod5_sequence_checker.sv
// Sequence monitor for a MOD-N counter: locks onto the 0..MODULUS-1 ramp,
// then flags wraps and violations and keeps wrap/error statistics.
module mod5_sequence_checker #(
    parameter int MODULUS    = 5,
    parameter int CNT_W      = 3,
    parameter int LOCK_STEPS = 5,
    parameter int ERR_W      = 8,
    parameter int WRAP_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [CNT_W-1:0]  q_in,
    output logic              locked,
    output logic              wrap,
    output logic              err,
    output logic              err_sticky,
    output logic [ERR_W-1:0]  err_count,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [CNT_W-1:0]  expected
);

    localparam int                GOOD_W = $clog2(LOCK_STEPS + 1);
    localparam logic [CNT_W-1:0]  MAX_Q  = CNT_W'(MODULUS - 1);
    localparam logic [GOOD_W-1:0] LOCK_V = GOOD_W'(LOCK_STEPS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t              state_r, state_next_s;
    logic [CNT_W-1:0]    prev_r, prev_next_s;
    logic [GOOD_W-1:0]   good_cnt_r, good_next_s;
    logic                locked_r, wrap_r, err_r, err_sticky_r;
    logic [ERR_W-1:0]    err_count_r, err_count_next_s;
    logic [WRAP_W-1:0]   wrap_count_r, wrap_count_next_s;
    logic [CNT_W-1:0]    expected_r, expected_next_s;
    logic [CNT_W-1:0]    exp_next_s;
    logic                out_of_range_s, match_s, wrap_pulse_s, err_pulse_s;

    // Successor of a counter value, wrapping at MODULUS-1.
    function automatic logic [CNT_W-1:0] succ(input logic [CNT_W-1:0] v);
        return (v == MAX_Q) ? {CNT_W{1'b0}} : v + CNT_W'(1'b1);
    endfunction

    // Next-state, pulse and statistics decode for one sample.
    always_comb begin
        exp_next_s        = succ(prev_r);
        out_of_range_s    = (q_in > MAX_Q);
        match_s           = (q_in == exp_next_s);
        state_next_s      = state_r;
        prev_next_s       = prev_r;
        good_next_s       = good_cnt_r;
        wrap_pulse_s      = 1'b0;
        err_pulse_s       = 1'b0;
        if (enable) begin
            if (out_of_range_s) begin
                // prev is deliberately kept: an illegal value is never a reference
                err_pulse_s  = 1'b1;
                state_next_s = IDLE;
            end else begin
                prev_next_s = q_in;
                case (state_r)
                    IDLE: begin
                        good_next_s  = {GOOD_W{1'b0}};
                        state_next_s = ACQUIRE;
                    end
                    ACQUIRE: begin
                        if (match_s) begin
                            good_next_s = good_cnt_r + GOOD_W'(1'b1);
                            if (good_cnt_r == LOCK_V - GOOD_W'(1'b1)) begin
                                state_next_s = LOCKED;
                            end else begin
                                state_next_s = ACQUIRE;
                            end
                        end else begin
                            good_next_s  = {GOOD_W{1'b0}};
                            state_next_s = ACQUIRE;
                        end
                    end
                    LOCKED: begin
                        if (match_s) begin
                            // A correct step landing on 0 can only come from MODULUS-1
                            wrap_pulse_s = (q_in == {CNT_W{1'b0}});
                            state_next_s = LOCKED;
                        end else begin
                            err_pulse_s  = 1'b1;
                            good_next_s  = {GOOD_W{1'b0}};
                            state_next_s = ACQUIRE;
                        end
                    end
                    default: begin
                        state_next_s = IDLE;
                        prev_next_s  = {CNT_W{1'b0}};
                        good_next_s  = {GOOD_W{1'b0}};
                    end
                endcase
            end
        end else begin
            state_next_s = state_r;
        end

        if (err_pulse_s && (err_count_r != {ERR_W{1'b1}})) begin
            err_count_next_s = err_count_r + ERR_W'(1'b1);
        end else begin
            err_count_next_s = err_count_r;
        end
        if (wrap_pulse_s) begin
            wrap_count_next_s = wrap_count_r + WRAP_W'(1'b1);
        end else begin
            wrap_count_next_s = wrap_count_r;
        end
        if (state_next_s == IDLE) begin
            expected_next_s = {CNT_W{1'b0}};
        end else begin
            expected_next_s = succ(prev_next_s);
        end
    end

    // State and registered outputs, with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            prev_r       <= {CNT_W{1'b0}};
            good_cnt_r   <= {GOOD_W{1'b0}};
            locked_r     <= 1'b0;
            wrap_r       <= 1'b0;
            err_r        <= 1'b0;
            err_sticky_r <= 1'b0;
            err_count_r  <= {ERR_W{1'b0}};
            wrap_count_r <= {WRAP_W{1'b0}};
            expected_r   <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_next_s;
            prev_r       <= prev_next_s;
            good_cnt_r   <= good_next_s;
            locked_r     <= (state_next_s == LOCKED);
            wrap_r       <= wrap_pulse_s;
            err_r        <= err_pulse_s;
            err_sticky_r <= err_sticky_r | err_pulse_s;
            err_count_r  <= err_count_next_s;
            wrap_count_r <= wrap_count_next_s;
            expected_r   <= expected_next_s;
        end
    end

    assign locked     = locked_r;
    assign wrap       = wrap_r;
    assign err        = err_r;
    assign err_sticky = err_sticky_r;
    assign err_count  = err_count_r;
    assign wrap_count = wrap_count_r;
    assign expected   = expected_r;

endmodule
